// File: rtl/exu_alu_datapath_mc.sv
// Multi-cycle integer ALU: 1-cycle ops plus iterative shifter.
// Optional min/max ops enabled by defining ALU_MINMAX_EN.
module exu_alu_datapath_mc #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      op_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            cmp_res_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW:0] STEP_W = (CW+1)'(SHIFT_STEP);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_BEQ  = 5'd10;
  localparam logic [4:0] OP_BNE  = 5'd11;
  localparam logic [4:0] OP_BLT  = 5'd12;
  localparam logic [4:0] OP_BLTU = 5'd13;
  localparam logic [4:0] OP_BGE  = 5'd14;
  localparam logic [4:0] OP_BGEU = 5'd15;
`ifdef ALU_MINMAX_EN
  localparam logic [4:0] OP_MIN  = 5'd16;
  localparam logic [4:0] OP_MAX  = 5'd17;
  localparam logic [4:0] OP_MINU = 5'd18;
  localparam logic [4:0] OP_MAXU = 5'd19;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            cmp_q, cmp_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            right_q, right_d;
  logic            fill_q, fill_d;

  logic [CW-1:0]   shamt;
  logic            accept;
  logic            is_shift;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] alu_res;
  logic            alu_cmp;
  logic [CW:0]     cnt_ext;
  logic [CW:0]     step;
  logic            last;
  logic [XLEN-1:0] sh_next;

  assign shamt    = op2_i[CW-1:0];
  assign is_shift = (op_i == OP_SLL) | (op_i == OP_SRL) | (op_i == OP_SRA);
  assign lt_s     = $signed(op1_i) < $signed(op2_i);
  assign lt_u     = op1_i < op2_i;
  assign eq       = op1_i == op2_i;

  assign req_ready_o = ~flush_i &
                       ((state_q == IDLE) |
                        ((state_q == DONE) & res_ready_i));
  assign accept      = req_valid_i & req_ready_o;
  assign res_valid_o = state_q == DONE;
  assign busy_o      = state_q != IDLE;
  assign res_o       = res_valid_o ? res_q : '0;
  assign cmp_res_o   = res_valid_o & cmp_q;

  // Single-cycle result; shifts only reach here with amount 0
  always_comb begin
    alu_res = '0;
    alu_cmp = 1'b0;
    case (op_i)
      OP_ADD:  alu_res = op1_i + op2_i;
      OP_SUB:  alu_res = op1_i - op2_i;
      OP_SLL:  alu_res = op1_i;
      OP_SRL:  alu_res = op1_i;
      OP_SRA:  alu_res = op1_i;
      OP_SLT:  alu_res = XLEN'(lt_s);
      OP_SLTU: alu_res = XLEN'(lt_u);
      OP_XOR:  alu_res = op1_i ^ op2_i;
      OP_OR:   alu_res = op1_i | op2_i;
      OP_AND:  alu_res = op1_i & op2_i;
      OP_BEQ:  alu_cmp = eq;
      OP_BNE:  alu_cmp = ~eq;
      OP_BLT:  alu_cmp = lt_s;
      OP_BLTU: alu_cmp = lt_u;
      OP_BGE:  alu_cmp = ~lt_s;
      OP_BGEU: alu_cmp = ~lt_u;
`ifdef ALU_MINMAX_EN
      OP_MIN:  alu_res = lt_s ? op1_i : op2_i;
      OP_MAX:  alu_res = lt_s ? op2_i : op1_i;
      OP_MINU: alu_res = lt_u ? op1_i : op2_i;
      OP_MAXU: alu_res = lt_u ? op2_i : op1_i;
`endif
      default: ;
    endcase
  end

  // One iterative shift step of min(SHIFT_STEP, remaining)
  always_comb begin
    logic signed [XLEN:0] sh_ext;
    cnt_ext = {1'b0, cnt_q};
    step    = (cnt_ext > STEP_W) ? STEP_W : cnt_ext;
    last    = cnt_ext == step;
    sh_ext  = {fill_q, sh_q};
    if (right_q) begin
      sh_next = XLEN'(sh_ext >>> step);
    end else begin
      sh_next = sh_q << step;
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cmp_d   = cmp_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    fill_d  = fill_q;
    if (flush_i) begin
      state_d = IDLE;
      res_d   = '0;
      cmp_d   = 1'b0;
      sh_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SHIFT: begin
          sh_d  = sh_next;
          cnt_d = CW'(cnt_ext - step);
          if (last) begin
            state_d = DONE;
            res_d   = sh_next;
            cmp_d   = 1'b0;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state_d = IDLE;
            res_d   = '0;
            cmp_d   = 1'b0;
          end
        end
        default: ;
      endcase
      if (accept) begin
        if (is_shift && (shamt != '0)) begin
          state_d = SHIFT;
          sh_d    = op1_i;
          cnt_d   = shamt;
          right_d = op_i != OP_SLL;
          fill_d  = (op_i == OP_SRA) & op1_i[XLEN-1];
          res_d   = '0;
          cmp_d   = 1'b0;
        end else begin
          state_d = DONE;
          res_d   = alu_res;
          cmp_d   = alu_cmp;
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      cmp_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cmp_q   <= cmp_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_exu_alu_datapath_mc.sv
// Randomized + directed bench for exu_alu_datapath_mc.
// Transaction-level reference model with per-cycle output compare.
module tb_exu_alu_datapath_mc;

  localparam int XLEN = 32;
  localparam int SS   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready_o;
  logic [XLEN-1:0] op1, op2;
  logic [4:0]      op;
  logic            flush;
  logic            res_valid_o;
  logic            res_ready;
  logic [XLEN-1:0] res_o;
  logic            cmp_res_o;
  logic            busy_o;

  always #5 clk = ~clk;

  exu_alu_datapath_mc #(.XLEN(XLEN), .SHIFT_STEP(SS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .op1_i(op1), .op2_i(op2), .op_i(op),
    .flush_i(flush),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready),
    .res_o(res_o), .cmp_res_o(cmp_res_o), .busy_o(busy_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: 0 idle, 1 working, 2 result held
  int          m_ph = 0;
  int          m_wait = 0;
  logic [31:0] m_res = '0;
  logic        m_cmp = 1'b0;

  function automatic void ref_op(input logic [4:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] r,
                                 output logic c,
                                 output int lat);
    int sh;
    logic sl, ul;
    sh  = int'(b % 32);
    sl  = $signed(a) < $signed(b);
    ul  = a < b;
    r   = '0;
    c   = 1'b0;
    lat = 1;
    case (o)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << sh;
      5'd3:  r = sl ? 32'd1 : 32'd0;
      5'd4:  r = ul ? 32'd1 : 32'd0;
      5'd5:  r = a ^ b;
      5'd6:  r = a >> sh;
      5'd7:  r = 32'($signed(a) >>> sh);
      5'd8:  r = a | b;
      5'd9:  r = a & b;
      5'd10: c = a == b;
      5'd11: c = a != b;
      5'd12: c = sl;
      5'd13: c = ul;
      5'd14: c = !sl;
      5'd15: c = !ul;
`ifdef ALU_MINMAX_EN
      5'd16: r = sl ? a : b;
      5'd17: r = sl ? b : a;
      5'd18: r = ul ? a : b;
      5'd19: r = ul ? b : a;
`endif
      default: ;
    endcase
    if (o == 5'd2 || o == 5'd6 || o == 5'd7)
      lat = 1 + (sh + SS - 1) / SS;
  endfunction

  function automatic logic m_ready();
    return !flush && (m_ph == 0 || (m_ph == 2 && res_ready));
  endfunction

  task automatic model_step();
    logic [31:0] r;
    logic c;
    int lat;
    bit acc;
    acc = req_valid && m_ready();
    if (flush) begin
      m_ph = 0;
      return;
    end
    if (m_ph == 1) begin
      m_wait--;
      if (m_wait == 0) m_ph = 2;
    end else if (m_ph == 2 && res_ready) begin
      m_ph = 0;
    end
    if (acc) begin
      ref_op(op, op1, op2, r, c, lat);
      m_res = r;
      m_cmp = c;
      if (lat == 1) m_ph = 2;
      else begin
        m_ph = 1;
        m_wait = lat - 1;
      end
    end
  endtask

  task automatic compare();
    chk("req_ready", req_ready_o, m_ready());
    chk("res_valid", res_valid_o, m_ph == 2);
    chk("busy", busy_o, m_ph != 0);
    chk("res", res_o, (m_ph == 2) ? m_res : 32'd0);
    chk("cmp", cmp_res_o, (m_ph == 2) ? m_cmp : 1'b0);
  endtask

  // Called at a negedge after inputs are driven
  task automatic tick();
    #1;
    compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    bit rdy;
    bit done;
    done = 0;
    req_valid = 1'b1;
    op = o;
    op1 = a;
    op2 = b;
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = m_ready();
      tick();
      if (rdy) done = 1;
    end
    if (!done) chk("issue_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 1;
    while (!res_valid_o && k < 30) begin
      tick();
      k++;
    end
  endtask

  task automatic run_op(input string nm, input logic [4:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec,
                        input int el);
    int k;
    res_ready = 1'b0;
    issue(o, a, b);
    wait_valid(k);
    chk({nm, "_lat"}, k, el);
    chk({nm, "_res"}, res_o, er);
    chk({nm, "_cmp"}, cmp_res_o, ec);
    chk({nm, "_model"}, m_res, er);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int k;
    rst_n = 1'b0;
    req_valid = 1'b0;
    op = '0;
    op1 = '0;
    op2 = '0;
    flush = 1'b0;
    res_ready = 1'b0;
    #12;
    chk("rst_valid", res_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_res", res_o, 0);
    chk("rst_cmp", cmp_res_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", req_ready_o, 1);
    @(negedge clk);

    // Long left shift: 1 + ceil(31/4) cycles, busy throughout
    res_ready = 1'b0;
    issue(5'd2, 32'h1, 32'd31);
    k = 1;
    while (!res_valid_o && k < 30) begin
      chk("sll_busy", busy_o, 1);
      tick();
      k++;
    end
    chk("sll31_lat", k, 9);
    chk("sll31_res", res_o, 32'h8000_0000);
    res_ready = 1'b1;
    tick();

    run_op("sra4", 5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 2);
    run_op("srl0", 5'd6, 32'h1234, 32'd0, 32'h1234, 0, 1);
    run_op("sll32", 5'd2, 32'h5, 32'd32, 32'h5, 0, 1);
    run_op("srl5", 5'd6, 32'hF000_0000, 32'd5, 32'h0780_0000, 0, 3);
    run_op("bltu", 5'd13, 32'h1, 32'hFFFF_FFFF, 32'h0, 1, 1);
    run_op("blt", 5'd12, 32'h1, 32'hFFFF_FFFF, 32'h0, 0, 1);
    run_op("beq", 5'd10, 32'd5, 32'd5, 32'h0, 1, 1);
    run_op("slt", 5'd3, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1);
    run_op("rsv", 5'd25, 32'h3, 32'h4, 32'h0, 0, 1);
`ifdef ALU_MINMAX_EN
    run_op("min", 5'd16, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 0, 1);
    run_op("minu", 5'd18, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 1);
`else
    run_op("min", 5'd16, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1);
    run_op("minu", 5'd18, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 1);
`endif

    // Backpressured ADD, then back-to-back SUB
    res_ready = 1'b0;
    issue(5'd0, 32'h7FFF_FFFF, 32'h1);
    wait_valid(k);
    chk("add_lat", k, 1);
    for (int i = 0; i < 3; i++) begin
      chk("add_hold", res_o, 32'h8000_0000);
      chk("add_noready", req_ready_o, 0);
      tick();
    end
    res_ready = 1'b1;
    req_valid = 1'b1;
    op = 5'd1;
    op1 = 32'd5;
    op2 = 32'd7;
    #1;
    chk("b2b_ready", req_ready_o, 1);
    tick();
    req_valid = 1'b0;
    res_ready = 1'b0;
    chk("sub_valid", res_valid_o, 1);
    chk("sub_res", res_o, 32'hFFFF_FFFE);
    res_ready = 1'b1;
    tick();

    // Flush during third shift cycle
    res_ready = 1'b0;
    issue(5'd2, 32'h1, 32'd31);
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("flush_ready", req_ready_o, 0);
    tick();
    flush = 1'b0;
    chk("flush_busy", busy_o, 0);
    for (int i = 0; i < 12; i++) begin
      chk("flush_novalid", res_valid_o, 0);
      tick();
    end

    // Asynchronous reset mid-shift
    issue(5'd2, 32'h1, 32'd31);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_valid", res_valid_o, 0);
    chk("amid_busy", busy_o, 0);
    chk("amid_res", res_o, 0);
    chk("amid_cmp", cmp_res_o, 0);
    m_ph = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("rst_novalid", res_valid_o, 0);
      tick();
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req_valid = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 2) == 0)
        op = 5'($urandom_range(0, 2) == 0 ? 2 : ($urandom_range(0, 1) ? 6 : 7));
      else
        op = 5'($urandom_range(0, 31));
      op1 = pick();
      op2 = pick();
      res_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 40) == 0;
      tick();
    end
    flush = 1'b0;
    req_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
